serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/adder_pkg.sv | 13 +
 rtl/paralleladder.sv | 23 ++
 rtl/serial_add_ctrl.sv | 121 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder: controller state encoding
// and the width of the single adder slice.
package adder_pkg;

   localparam int unsigned SliceW = 4;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

endpackage

// File: rtl/paralleladder.sv
// One ripple-carry adder slice, SliceW bits wide. Purely combinational.
module paralleladder
   import adder_pkg::*;
(
   input  logic [SliceW-1:0] a,
   input  logic [SliceW-1:0] b,
   input  logic              ci,
   output logic [SliceW-1:0] s,
   output logic              co
);

   logic [SliceW:0] c;

   assign c[0] = ci;

   for (genvar i = 0; i < SliceW; i++) begin : g_bit
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign co = c[SliceW];

endmodule

// File: rtl/serial_add_ctrl.sv
// Nibble-serial adder controller. Captures an operand set, adds one nibble per
// cycle (LSB first) through a single shared slice, then holds the result until
// the consumer takes it.
module serial_add_ctrl
   import adder_pkg::*;
#(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [SliceW*NIBBLES-1:0] op_a,
   input  logic [SliceW*NIBBLES-1:0] op_b,
   input  logic                      cin,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [SliceW*NIBBLES-1:0] sum,
   output logic                      cout
);

   localparam int unsigned W     = SliceW * NIBBLES;
   localparam int unsigned IdxW  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   // Wide enough to hold the bit offset of the top nibble.
   localparam int unsigned BaseW = IdxW + 2;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

   state_e            state_q, state_d;
   logic [IdxW-1:0]   idx_q, idx_d;
   logic              carry_q, carry_d;
   logic [W-1:0]      a_q, a_d;
   logic [W-1:0]      b_q, b_d;
   logic [W-1:0]      sum_q, sum_d;
   logic              cout_q, cout_d;

   logic [BaseW-1:0]  base;
   logic [SliceW-1:0] a_nib, b_nib, slice_s;
   logic              slice_co;

   assign base  = BaseW'(idx_q) * BaseW'(SliceW);
   assign a_nib = a_q[base +: SliceW];
   assign b_nib = b_q[base +: SliceW];

   paralleladder u_slice (
      .a  (a_nib),
      .b  (b_nib),
      .ci (carry_q),
      .s  (slice_s),
      .co (slice_co)
   );

   // Next-state and handshake outputs for the IDLE -> RUN -> DONE sequence.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      carry_d   = carry_q;
      a_d       = a_q;
      b_d       = b_q;
      sum_d     = sum_q;
      cout_d    = cout_q;
      in_ready  = (state_q == StIdle);
      out_valid = (state_q == StDone);

      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               a_d     = op_a;
               b_d     = op_b;
               carry_d = cin;
               idx_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            sum_d[base +: SliceW] = slice_s;
            carry_d               = slice_co;
            if (idx_q == LastIdx) begin
               cout_d  = slice_co;
               idx_d   = '0;
               state_d = StDone;
            end else begin
               idx_d = idx_q + IdxW'(1);
            end
         end
         StDone: begin
            // A fresh accept waits one cycle in IDLE after the handshake.
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers; reset discards any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: one NIBBLES=4 instance and one NIBBLES=2
// instance sharing clock and reset.
module tb_serial_add_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        iv4, or4, cin4;
   logic [15:0] a4, b4;
   logic        ir4, ov4, co4;
   logic [15:0] s4;

   logic        iv2, or2, cin2;
   logic [7:0]  a2, b2;
   logic        ir2, ov2, co2;
   logic [7:0]  s2;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   serial_add_ctrl #(.NIBBLES(4)) dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv4),
      .in_ready  (ir4),
      .op_a      (a4),
      .op_b      (b4),
      .cin       (cin4),
      .out_valid (ov4),
      .out_ready (or4),
      .sum       (s4),
      .cout      (co4)
   );

   serial_add_ctrl #(.NIBBLES(2)) dut2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv2),
      .in_ready  (ir2),
      .op_a      (a2),
      .op_b      (b2),
      .cin       (cin2),
      .out_valid (ov2),
      .out_ready (or2),
      .sum       (s2),
      .cout      (co2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one operand set to an idle instance and wait for out_valid.
   // lat is the number of edges from accept to the first edge seeing out_valid.
   task automatic run_add(input int which, input logic [15:0] a, input logic [15:0] b,
                          input logic c, output logic [15:0] s, output logic co,
                          output int lat);
      if (which == 2) begin
         check("idle_ready2", 32'(ir2), 32'd1);
         a2 = a[7:0]; b2 = b[7:0]; cin2 = c; iv2 = 1'b1;
      end else begin
         check("idle_ready4", 32'(ir4), 32'd1);
         a4 = a; b4 = b; cin4 = c; iv4 = 1'b1;
      end
      tick();
      iv2 = 1'b0;
      iv4 = 1'b0;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if ((which == 2) ? ov2 : ov4) begin
            lat = k + 1;
            break;
         end
      end
      if (which == 2) begin
         s = {8'h00, s2}; co = co2;
      end else begin
         s = s4; co = co4;
      end
   endtask

   task automatic release_out(input int which);
      if (which == 2) or2 = 1'b1; else or4 = 1'b1;
      tick();
      if (which == 2) begin
         check("post_hs_valid2", 32'(ov2), 32'd0);
         check("post_hs_ready2", 32'(ir2), 32'd1);
         or2 = 1'b0;
      end else begin
         check("post_hs_valid4", 32'(ov4), 32'd0);
         check("post_hs_ready4", 32'(ir4), 32'd1);
         or4 = 1'b0;
      end
   endtask

   initial begin
      logic [15:0] s;
      logic        co;
      int          lat;
      int          acc_t[2];
      logic [15:0] res_s[2];
      logic        res_c[2];
      int          n_acc, n_res;
      logic        pre_ir, pre_ov, pre_co;
      logic [15:0] pre_s;

      rst_n = 1'b0;
      iv4 = 0; or4 = 0; cin4 = 0; a4 = '0; b4 = '0;
      iv2 = 0; or2 = 0; cin2 = 0; a2 = '0; b2 = '0;
      #12;
      check("rst_ready", 32'(ir4), 32'd1);
      check("rst_valid", 32'(ov4), 32'd0);
      check("rst_sum", 32'(s4), 32'd0);
      check("rst_cout", 32'(co4), 32'd0);
      check("rst_ready2", 32'(ir2), 32'd1);
      check("rst_valid2", 32'(ov2), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Basic add.
      run_add(4, 16'h1234, 16'h1111, 1'b0, s, co, lat);
      check("basic_sum", 32'(s), 32'h2345);
      check("basic_cout", 32'(co), 32'd0);
      check("basic_lat", 32'(lat), 32'd5);
      release_out(4);

      // Carry ripples through every nibble.
      run_add(4, 16'hFFFF, 16'h0000, 1'b1, s, co, lat);
      check("ripple_sum", 32'(s), 32'h0000);
      check("ripple_cout", 32'(co), 32'd1);
      check("ripple_lat", 32'(lat), 32'd5);
      release_out(4);

      // Backpressure: result held while inputs churn.
      run_add(4, 16'hABCD, 16'h1234, 1'b1, s, co, lat);
      check("bp_sum0", 32'(s), 32'hBE02);
      check("bp_cout0", 32'(co), 32'd0);
      for (int i = 0; i < 10; i++) begin
         iv4 = ~iv4;
         a4  = ~a4;
         tick();
         check("bp_sum", 32'(s4), 32'hBE02);
         check("bp_cout", 32'(co4), 32'd0);
         check("bp_ready", 32'(ir4), 32'd0);
         check("bp_valid", 32'(ov4), 32'd1);
      end
      iv4 = 1'b0;
      release_out(4);

      // Reset after two RUN cycles; carry register holds 1 at that point.
      a4 = 16'h12F9; b4 = 16'h0008; cin4 = 1'b0; iv4 = 1'b1;
      tick();
      iv4 = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("mid_rst_ready", 32'(ir4), 32'd1);
      check("mid_rst_valid", 32'(ov4), 32'd0);
      check("mid_rst_sum", 32'(s4), 32'd0);
      check("mid_rst_cout", 32'(co4), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      run_add(4, 16'h00FF, 16'h0001, 1'b0, s, co, lat);
      check("post_rst_sum", 32'(s), 32'h0100);
      check("post_rst_cout", 32'(co), 32'd0);
      check("post_rst_lat", 32'(lat), 32'd5);
      release_out(4);

      // Back-to-back with in_valid and out_ready both held high.
      n_acc = 0;
      n_res = 0;
      a4 = 16'h1111; b4 = 16'h2222; cin4 = 1'b0;
      iv4 = 1'b1; or4 = 1'b1;
      for (int cyc = 0; cyc < 40 && n_res < 2; cyc++) begin
         pre_ir = ir4;
         pre_ov = ov4;
         pre_s  = s4;
         pre_co = co4;
         tick();
         if (pre_ir && iv4) begin
            if (n_acc < 2) acc_t[n_acc] = cyc;
            n_acc++;
            if (n_acc == 1) begin
               a4 = 16'h0F0F; b4 = 16'h00F1; cin4 = 1'b1;
            end else begin
               iv4 = 1'b0;
            end
         end
         if (pre_ov && or4) begin
            if (n_res < 2) begin
               res_s[n_res] = pre_s;
               res_c[n_res] = pre_co;
            end
            n_res++;
         end
      end
      iv4 = 1'b0;
      or4 = 1'b0;
      check("b2b_accepts", 32'(n_acc), 32'd2);
      check("b2b_results", 32'(n_res), 32'd2);
      if (n_acc == 2 && n_res == 2) begin
         check("b2b_spacing", 32'(acc_t[1] - acc_t[0]), 32'd6);
         check("b2b_sum0", 32'(res_s[0]), 32'h3333);
         check("b2b_cout0", 32'(res_c[0]), 32'd0);
         check("b2b_sum1", 32'(res_s[1]), 32'h1001);
         check("b2b_cout1", 32'(res_c[1]), 32'd0);
      end
      tick();

      // Two-nibble instance.
      run_add(2, 16'h00FF, 16'h0001, 1'b0, s, co, lat);
      check("n2_sum", 32'(s), 32'h00);
      check("n2_cout", 32'(co), 32'd1);
      check("n2_lat", 32'(lat), 32'd3);
      release_out(2);
      run_add(2, 16'h005A, 16'h0033, 1'b0, s, co, lat);
      check("n2b_sum", 32'(s), 32'h8D);
      check("n2b_cout", 32'(co), 32'd0);
      check("n2b_lat", 32'(lat), 32'd3);
      release_out(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
